// File: rtl/audio_cal_sequencer.sv
// audio_cal_sequencer: brings the mic front-end from reset to steady state.
// After reset it waits a settling period counted in mic samples, then fires
// the offset calculator. It retries on timeout and enables the processed-audio
// path once an offset arrives. It also services run-time recalibration
// requests and flags a stalled mic sample stream.
// Ports:
//   audio_clk          sole clock
//   rst_n_in           asynchronous active-low reset
//   mic_data_valid_in  one-cycle pulse per raw mic sample
//   offset_produced_in one-cycle completion pulse from the offset calculator
//   recal_req_in       one-cycle recalibration request
//   offset_trigger_out one-cycle pulse that starts offset calculation
//   pipeline_en_out    high while processed audio is valid downstream
//   cal_fail_out       high while in FAULT
//   mic_stall_out      high while the sample stream is stalled
//   state_out          current state encoding
module audio_cal_sequencer #(
    parameter int SETTLE_SAMPLES      = 4800,
    parameter int CAL_TIMEOUT_SAMPLES = 16384,
    parameter int CAL_RETRIES         = 3,
    parameter int STALL_CLKS          = 4096
) (
    input  logic       audio_clk,
    input  logic       rst_n_in,
    input  logic       mic_data_valid_in,
    input  logic       offset_produced_in,
    input  logic       recal_req_in,
    output logic       offset_trigger_out,
    output logic       pipeline_en_out,
    output logic       cal_fail_out,
    output logic       mic_stall_out,
    output logic [2:0] state_out
);
    typedef enum logic [2:0] {
        SETTLE      = 3'd0,
        CAL_TRIG    = 3'd1,
        WAIT_OFFSET = 3'd2,
        RUN         = 3'd3,
        FAULT       = 3'd4
    } state_t;

    localparam int SMAX = (SETTLE_SAMPLES > CAL_TIMEOUT_SAMPLES) ? SETTLE_SAMPLES : CAL_TIMEOUT_SAMPLES;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int AW   = $clog2(CAL_RETRIES + 1);
    localparam int KW   = $clog2(STALL_CLKS + 1);

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_sample_cnt;
    logic [AW-1:0]   r_attempt_cnt;
    logic [KW-1:0]   r_stall_cnt;
    logic            w_counting;
    logic            w_timeout;

    assign w_counting = (r_state == SETTLE) || (r_state == WAIT_OFFSET);
    // The valid that brings the count up to the timeout, not the count itself
    assign w_timeout  = mic_data_valid_in && (r_sample_cnt == SW'(CAL_TIMEOUT_SAMPLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            SETTLE:      w_next = (mic_data_valid_in && r_sample_cnt == SW'(SETTLE_SAMPLES - 1)) ? CAL_TRIG : SETTLE;
            CAL_TRIG:    w_next = WAIT_OFFSET;
            // A completion pulse outranks a coincident timeout
            WAIT_OFFSET: w_next = offset_produced_in ? RUN :
                                  !w_timeout ? WAIT_OFFSET :
                                  (r_attempt_cnt < AW'(CAL_RETRIES)) ? CAL_TRIG : FAULT;
            RUN, FAULT:  w_next = recal_req_in ? CAL_TRIG : r_state;
            default:     w_next = SETTLE;
        endcase
    end

    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= SETTLE;
            r_sample_cnt  <= '0;
            r_attempt_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_next;
            r_sample_cnt  <= (r_state == CAL_TRIG) ? '0 :
                             (w_counting && mic_data_valid_in && r_sample_cnt != SW'(SMAX)) ? r_sample_cnt + 1'b1 :
                             r_sample_cnt;
            r_attempt_cnt <= (r_state == CAL_TRIG && r_attempt_cnt != AW'(CAL_RETRIES)) ? r_attempt_cnt + 1'b1 :
                             ((r_state == RUN || r_state == FAULT) && recal_req_in) ? '0 :
                             r_attempt_cnt;
            r_stall_cnt   <= mic_data_valid_in ? '0 :
                             (r_stall_cnt != KW'(STALL_CLKS)) ? r_stall_cnt + 1'b1 :
                             r_stall_cnt;
        end
    end

    assign offset_trigger_out = (r_state == CAL_TRIG);
    assign pipeline_en_out    = (r_state == RUN);
    assign cal_fail_out       = (r_state == FAULT);
    assign mic_stall_out      = (r_stall_cnt == KW'(STALL_CLKS));
    assign state_out          = r_state;
endmodule

// File: doc/audio_cal_sequencer.md
# audio_cal_sequencer

Sequences the microphone front-end (DC-offset calculator, anti-alias filter and decimator) from reset to steady state. After reset it waits a settling period counted in mic samples, then fires the offset-calculation trigger and waits for the calculator's completion pulse. It retries on timeout and only then enables the processed-audio path. It also services run-time recalibration requests and flags a stalled microphone sample stream.

## Interface
Parameters:
- SETTLE_SAMPLES, 4800, number of mic_data_valid_in pulses to wait before the first trigger (100 ms at 48 kHz); ≥1
- CAL_TIMEOUT_SAMPLES, 16384, valid pulses allowed in WAIT_OFFSET before a timeout; ≥1
- CAL_RETRIES, 3, total trigger attempts before FAULT; ≥1
- STALL_CLKS, 4096, audio_clk cycles without a valid pulse that declare a mic stall; ≥2

Ports:
- audio_clk  in  1  sole clock
- rst_n_in  in  1  asynchronous, active-low reset
- mic_data_valid_in  in  1  one-cycle pulse per raw mic sample
- offset_produced_in  in  1  one-cycle completion pulse from the offset calculator
- recal_req_in  in  1  one-cycle recalibration request
- offset_trigger_out  out  1  one-cycle pulse that starts offset calculation
- pipeline_en_out  out  1  high while processed audio is valid for downstream use
- cal_fail_out  out  1  high while in FAULT
- mic_stall_out  out  1  high while the sample stream is stalled
- state_out  out  3  current state encoding

## Operation
- States and encodings: SETTLE=0, CAL_TRIG=1, WAIT_OFFSET=2, RUN=3, FAULT=4. Codes 5–7 are unreachable; if entered, go to SETTLE.
- SETTLE: sample counter increments on each mic_data_valid_in. On the valid that makes the count equal SETTLE_SAMPLES, go to CAL_TRIG.
- CAL_TRIG: lasts exactly one cycle with offset_trigger_out=1.
  - Clears the sample counter.
  - Increments attempt_cnt.
  - Goes to WAIT_OFFSET.
- WAIT_OFFSET: counter increments on each valid.
  - offset_produced_in=1: go to RUN.
  - Otherwise, on the valid that makes the count equal CAL_TIMEOUT_SAMPLES: go to CAL_TRIG if attempt_cnt < CAL_RETRIES, else go to FAULT.
- RUN: pipeline_en_out=1. recal_req_in=1 clears attempt_cnt and goes to CAL_TRIG; pipeline_en_out drops with the state change.
- FAULT: cal_fail_out=1. Stays until recal_req_in=1, then clears attempt_cnt and goes to CAL_TRIG.
- Simultaneous events:
  - offset_produced_in and a timeout in the same cycle: offset_produced_in wins (go to RUN).
  - recal_req_in in SETTLE, CAL_TRIG or WAIT_OFFSET: ignored.
  - offset_produced_in outside WAIT_OFFSET: ignored.
- Stall watchdog runs in every state, independent of the FSM:
  - A cycle counter clears on each valid and otherwise saturates at STALL_CLKS.
  - mic_stall_out=1 while the counter equals STALL_CLKS; it clears the cycle after the next valid.
  - A stall does not change state or pipeline_en_out.
- Width rules:
  - The sample counter is sized to max(SETTLE_SAMPLES, CAL_TIMEOUT_SAMPLES).
  - The stall counter is sized to STALL_CLKS.
  - attempt_cnt is sized to CAL_RETRIES.
  - No counter wraps; all saturate or clear.

## Timing
- All outputs are registered and decoded from the state and counter registers; there are no combinational input-to-output paths.
- Reset values:
  - state SETTLE (state_out=0)
  - all counters 0
  - offset_trigger_out=0, pipeline_en_out=0, cal_fail_out=0, mic_stall_out=0
- Reset asserted mid-operation returns to SETTLE immediately and asynchronously. Any in-flight calibration is abandoned.
- offset_trigger_out rises on the edge after the settling valid is sampled and stays high exactly 1 cycle.
- pipeline_en_out rises on the edge after offset_produced_in is sampled. It falls on the edge after recal_req_in is sampled in RUN.
- At least 1 cycle always separates consecutive trigger pulses, because WAIT_OFFSET is held ≥1 cycle.

## Test plan
Bench parameters: SETTLE_SAMPLES=4, CAL_TIMEOUT_SAMPLES=8, CAL_RETRIES=2, STALL_CLKS=10, valid every 4 clocks.
- Nominal bring-up: release reset, pulse offset_produced_in 5 valids after the trigger → exactly one offset_trigger_out pulse, one cycle after the 4th valid; pipeline_en_out=1 one cycle after offset_produced_in; state_out=3.
- Retry then success: no offset on the first attempt → a second trigger one cycle after the 8th valid in WAIT_OFFSET; offset_produced_in on attempt 2 → RUN; cal_fail_out stays 0.
- Exhausted retries: never send offset_produced_in → exactly 2 trigger pulses, then state_out=4 and cal_fail_out=1; recal_req_in → trigger pulse, cal_fail_out=0.
- Recal in RUN, and collisions:
  - recal_req_in in RUN → pipeline_en_out=0 next cycle and one trigger pulse.
  - offset_produced_in coincident with the timeout valid → RUN with no extra trigger.
  - recal_req_in during WAIT_OFFSET → ignored.
- Stall and async reset:
  - Withhold valids for 10 clocks → mic_stall_out=1; next valid → 0; state unchanged.
  - Assert rst_n_in low mid-WAIT_OFFSET, between clock edges → outputs reset immediately and state_out=0.
